// File: rtl/segdac_bias_sweeper.sv
// segdac_bias_sweeper: frame-synchronous sweep of Vbias code x segment level, with RGB/bias passthrough when idle.
module segdac_bias_sweeper #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        sweep_start,
  input  logic        sweep_abort,
  input  logic [2:0]  cfg_bias,
  input  logic [23:0] rgb_in,
  output logic [23:0] rgb_out,
  output logic [2:0]  bias_out,
  output logic        busy,
  output logic        done,
  output logic [4:0]  step_idx
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);
  state_t      state_q;
  logic [2:0]  bias_q;
  logic        busy_q, done_q, force_q;
  logic [4:0]  step_q, step_d;
  logic [7:0]  cnt_q;
  logic [7:0]  lvl8;
  assign step_d   = step_q + 5'd1;
  assign lvl8     = {4{step_q[1:0]}};
  // Forced colour is combinational so the override stays pixel-aligned with the generator's syncs.
  assign rgb_out  = force_q ? {3{lvl8}} : rgb_in;
  assign bias_out = bias_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bias_q  <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      force_q <= 1'b0;
      step_q  <= 5'd0;
      cnt_q   <= 8'd0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && sweep_abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        force_q <= 1'b0;
        step_q  <= 5'd0;
        cnt_q   <= 8'd0;
        bias_q  <= cfg_bias;
      end else begin
        case (state_q)
          IDLE: begin
            bias_q <= cfg_bias;
            if (sweep_start && !sweep_abort) begin
              state_q <= ARM;
              busy_q  <= 1'b1;
            end
          end
          ARM: begin
            bias_q <= cfg_bias;
            if (frame_tick) begin
              state_q <= RUN;
              force_q <= 1'b1;
              step_q  <= 5'd0;
              cnt_q   <= 8'd0;
              bias_q  <= 3'b000;
            end
          end
          RUN: begin
            if (frame_tick) begin
              if (cnt_q == LAST) begin
                cnt_q <= 8'd0;
                if (step_q == 5'd31) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  force_q <= 1'b0;
                  done_q  <= 1'b1;
                  step_q  <= 5'd0;
                  bias_q  <= cfg_bias;
                end else begin
                  step_q <= step_d;
                  bias_q <= step_d[4:2];
                end
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_segdac_bias_sweeper.sv
// tb_segdac_bias_sweeper: two instances (1 and 4 frames/step) checked against a tick-counting reference model.
module tb_segdac_bias_sweeper;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0, sweep_start = 1'b0, sweep_abort = 1'b0;
  logic [2:0]  cfg_bias = 3'd0;
  logic [23:0] rgb_in = 24'd0;
  logic [23:0] rgb_o [2];
  logic [2:0]  bias_o [2];
  logic        busy_o [2], done_o [2];
  logic [4:0]  step_o [2];

  segdac_bias_sweeper #(.FRAMES_PER_STEP(1)) u_f1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .sweep_start(sweep_start),
    .sweep_abort(sweep_abort), .cfg_bias(cfg_bias), .rgb_in(rgb_in), .rgb_out(rgb_o[0]),
    .bias_out(bias_o[0]), .busy(busy_o[0]), .done(done_o[0]), .step_idx(step_o[0]));
  segdac_bias_sweeper #(.FRAMES_PER_STEP(4)) u_f4 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .sweep_start(sweep_start),
    .sweep_abort(sweep_abort), .cfg_bias(cfg_bias), .rgb_in(rgb_in), .rgb_out(rgb_o[1]),
    .bias_out(bias_o[1]), .busy(busy_o[1]), .done(done_o[1]), .step_idx(step_o[1]));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fps [2] = '{1, 4};
  int mode [2];
  int ticks [2];
  logic [2:0] bm [2];
  bit dm [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; ticks[i] = 0; bm[i] = 3'd0; dm[i] = 1'b0;
    end
  endfunction

  // mode: 0 idle, 1 armed, 2 running; ticks counts frame ticks since the arming tick.
  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      dm[i] = 1'b0;
      if (mode[i] == 0) begin
        bm[i] = cfg_bias;
        if (sweep_start && !sweep_abort) mode[i] = 1;
      end else if (sweep_abort) begin
        mode[i] = 0; bm[i] = cfg_bias;
      end else if (mode[i] == 1) begin
        bm[i] = cfg_bias;
        if (frame_tick) begin mode[i] = 2; ticks[i] = 0; bm[i] = 3'd0; end
      end else if (frame_tick) begin
        ticks[i]++;
        if (ticks[i] == 32 * fps[i]) begin
          mode[i] = 0; dm[i] = 1'b1; bm[i] = cfg_bias;
        end else bm[i] = 3'((ticks[i] / fps[i]) / 4);
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int st;
      logic [7:0] lv;
      st = (mode[i] == 2) ? ticks[i] / fps[i] : 0;
      lv = 8'((st % 4) * 85);
      check($sformatf("rgb_f%0d", fps[i]), 32'(rgb_o[i]), 32'((mode[i] == 2) ? {lv, lv, lv} : rgb_in));
      check($sformatf("bias_f%0d", fps[i]), 32'(bias_o[i]), 32'(bm[i]));
      check($sformatf("busy_f%0d", fps[i]), 32'(busy_o[i]), 32'(mode[i] != 0));
      check($sformatf("done_f%0d", fps[i]), 32'(done_o[i]), 32'(dm[i]));
      check($sformatf("step_f%0d", fps[i]), 32'(step_o[i]), 32'(st));
    end
  endtask

  task automatic cyc(input bit t, input bit s, input bit a);
    frame_tick = t; sweep_start = s; sweep_abort = a;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    frame_tick = 1'b0; sweep_start = 1'b0; sweep_abort = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3 check_all();
    #9 rst_n = 1'b1;
    cfg_bias = 3'b101; rgb_in = 24'h123456;
    #1 check("idle_rgb", 32'(rgb_o[0]), 32'h123456);
    cyc(0, 0, 0);
    check("idle_bias", 32'(bias_o[0]), 32'h5);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("arm_busy", 32'(busy_o[0]), 32'h1);
    check("arm_rgb", 32'(rgb_o[0]), 32'h123456);
    cyc(1, 0, 0);
    check("armed_rgb", 32'(rgb_o[0]), 32'h0);
    check("armed_bias", 32'(bias_o[0]), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      rgb_in = 24'($urandom);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      if (k == 5) begin
        check("t5_step", 32'(step_o[0]), 32'd5);
        check("t5_bias", 32'(bias_o[0]), 32'h1);
        check("t5_rgb", 32'(rgb_o[0]), 32'h555555);
      end
      if (k == 31) begin
        check("t31_step", 32'(step_o[0]), 32'd31);
        check("t31_bias", 32'(bias_o[0]), 32'h7);
        check("t31_rgb", 32'(rgb_o[0]), 32'hFFFFFF);
      end
    end
    check("t32_done", 32'(done_o[0]), 32'h1);
    check("t32_busy", 32'(busy_o[0]), 32'h0);
    check("t32_bias", 32'(bias_o[0]), 32'h5);
    check("t32_rgb", 32'(rgb_o[0]), 32'(rgb_in));
    check("t32_f4_step", 32'(step_o[1]), 32'd8);
    cyc(0, 0, 0);
    check("done_once", 32'(done_o[0]), 32'h0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    for (int k = 0; k < 10; k++) cyc(1, 0, 0);
    check("pre_abort_step", 32'(step_o[0]), 32'd10);
    cyc(1, 0, 1);
    check("abort_step", 32'(step_o[0]), 32'd0);
    check("abort_done", 32'(done_o[0]), 32'h0);
    check("abort_rgb", 32'(rgb_o[0]), 32'(rgb_in));
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    for (int k = 0; k < 17; k++) begin
      cyc(1, 0, 0);
      if (k == 3) cyc(0, 1, 0);
    end
    check("pre_rst_step", 32'(step_o[0]), 32'd17);
    async_reset();
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    check("restart_step", 32'(step_o[0]), 32'd0);
    for (int n = 0; n < 4000; n++) begin
      rgb_in = 24'($urandom);
      cfg_bias = 3'($urandom);
      if ($urandom_range(0, 1999) == 0) async_reset();
      else cyc($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 599) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
